// File: rtl/prog_gpio_v2.sv
// prog_gpio_v2: Avalon-MM programmable GPIO with per-bit direction, atomic set/clear and
// level/edge interrupt capture. Define GPIO_DEBOUNCE_EN to insert a per-bit debounce filter.
module prog_gpio_v2 #(
  parameter int unsigned W               = 32,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter logic [31:0] OUT_RESET       = 32'h0,
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         avs_write,
  input  logic [31:0]  avs_writedata,
  input  logic [4:0]   avs_address,
  output logic [31:0]  avs_readdata,
  input  logic [W-1:0] pio_i,
  output logic [W-1:0] pio_o,
  output logic [W-1:0] pio_oe,
  output logic         irq
);

  localparam logic [4:0] ADDR_DATA   = 5'h00;
  localparam logic [4:0] ADDR_DIR    = 5'h04;
  localparam logic [4:0] ADDR_MASK   = 5'h08;
  localparam logic [4:0] ADDR_MODE   = 5'h0C;
  localparam logic [4:0] ADDR_POL    = 5'h10;
  localparam logic [4:0] ADDR_STATUS = 5'h14;
  localparam logic [4:0] ADDR_SET    = 5'h18;
  localparam logic [4:0] ADDR_CLR    = 5'h1C;

  if (W < 1 || W > 32) begin : g_bad_w
    $error("prog_gpio_v2: W must be within 1..32");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("prog_gpio_v2: SYNC_STAGES must be at least 2");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_db
    $error("prog_gpio_v2: DEBOUNCE_CYCLES must be at least 1");
  end

  logic [W-1:0] data_out_r, dir_r, mask_r, mode_r, pol_r, status_r, prev_r;
  logic         irq_r;
  logic [W-1:0] sync_r [SYNC_STAGES];
  logic [W-1:0] in_s, in_f, wdata_s, w1c_s, rise_s, fall_s, edge_ev_s, lvl_ev_s, ev_s, rd_s;

  assign wdata_s = avs_writedata[W-1:0];
  assign in_s    = sync_r[SYNC_STAGES-1];

  // Input synchroniser chain
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_r[k] <= {W{1'b0}};
    end else begin
      sync_r[0] <= pio_i;
      for (int k = 1; k < SYNC_STAGES; k++) sync_r[k] <= sync_r[k-1];
    end
  end

`ifdef GPIO_DEBOUNCE_EN
  localparam int unsigned   CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0] cnt_r [W];
  logic [W-1:0]  filt_r;

  // Debounce: a bit follows in_s only after DEBOUNCE_CYCLES consecutive disagreeing cycles
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      filt_r <= {W{1'b0}};
      for (int i = 0; i < W; i++) cnt_r[i] <= {CW{1'b0}};
    end else begin
      for (int i = 0; i < W; i++) begin
        if (in_s[i] == filt_r[i]) begin
          cnt_r[i] <= {CW{1'b0}};
        end else if (cnt_r[i] == CNT_LAST) begin
          filt_r[i] <= in_s[i];
          cnt_r[i]  <= {CW{1'b0}};
        end else begin
          cnt_r[i] <= cnt_r[i] + CW'(1);
        end
      end
    end
  end

  assign in_f = filt_r;
`else
  assign in_f = in_s;
`endif

  // Output pins never raise events; prev_r keeps tracking regardless of DIR/MASK
  assign rise_s    = in_f & ~prev_r;
  assign fall_s    = ~in_f & prev_r;
  assign edge_ev_s = (pol_r & rise_s) | (~pol_r & fall_s);
  assign lvl_ev_s  = ~(in_f ^ pol_r);
  assign ev_s      = ~dir_r & ((mode_r & edge_ev_s) | (~mode_r & lvl_ev_s));
  assign w1c_s     = (avs_write && (avs_address == ADDR_STATUS)) ? wdata_s : {W{1'b0}};

  // Control registers and atomic output set/clear
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_out_r <= OUT_RESET[W-1:0];
      dir_r      <= {W{1'b0}};
      mask_r     <= {W{1'b0}};
      mode_r     <= {W{1'b0}};
      pol_r      <= {W{1'b0}};
    end else if (avs_write) begin
      case (avs_address)
        ADDR_DATA: data_out_r <= wdata_s;
        ADDR_DIR:  dir_r      <= wdata_s;
        ADDR_MASK: mask_r     <= wdata_s;
        ADDR_MODE: mode_r     <= wdata_s;
        ADDR_POL:  pol_r      <= wdata_s;
        ADDR_SET:  data_out_r <= data_out_r | wdata_s;
        ADDR_CLR:  data_out_r <= data_out_r & ~wdata_s;
        default:   data_out_r <= data_out_r;
      endcase
    end
  end

  // Sticky status (a new event beats a simultaneous W1C), edge history and irq
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      status_r <= {W{1'b0}};
      prev_r   <= {W{1'b0}};
      irq_r    <= 1'b0;
    end else begin
      status_r <= (status_r & ~w1c_s) | ev_s;
      prev_r   <= in_f;
      irq_r    <= |(status_r & mask_r);
    end
  end

  // Zero-wait-state read decode
  always_comb begin
    rd_s = {W{1'b0}};
    case (avs_address)
      ADDR_DATA:   rd_s = (dir_r & data_out_r) | (~dir_r & in_f);
      ADDR_DIR:    rd_s = dir_r;
      ADDR_MASK:   rd_s = mask_r;
      ADDR_MODE:   rd_s = mode_r;
      ADDR_POL:    rd_s = pol_r;
      ADDR_STATUS: rd_s = status_r;
      default:     rd_s = {W{1'b0}};
    endcase
  end

  assign avs_readdata = 32'(rd_s);
  assign pio_o        = data_out_r;
  assign pio_oe       = dir_r;
  assign irq          = irq_r;

endmodule

// File: doc/prog_gpio_v2.md
Name: prog_gpio_v2

Overview:
- Parametrised successor of the team's Avalon-MM programmable GPIO controller, for HPS/Nios sub-systems on the DE1-SoC.
- Provides W bidirectional pins with a per-bit direction register and atomic set/clear of outputs.
- Input path: synchroniser, then optional debounce, then per-bit level/edge interrupt capture with sticky write-1-to-clear status.
- Drives a single registered irq line to the processor interrupt controller.

Parameters:
- W, 32: number of GPIO bits, legal range 1..32. Bus bits [31:W] read 0 and are ignored on write.
- SYNC_STAGES, 2: input synchroniser depth, minimum 2.
- OUT_RESET, 32'h0: reset value of the output register (low W bits used).
- DEBOUNCE_CYCLES, 16: stable-cycle count for debounce, minimum 1. Used only with GPIO_DEBOUNCE_EN.

Ports:
- clk  in  1  system clock; the only clock.
- reset_n  in  1  asynchronous active-low reset.
- avs_write  in  1  Avalon write strobe, single-cycle.
- avs_writedata  in  32  write data.
- avs_address  in  5  byte address (word-aligned registers).
- avs_readdata  out  32  combinational read data, zero wait states.
- pio_i  in  W  asynchronous pin inputs.
- pio_o  out  W  output register value.
- pio_oe  out  W  output enable (= DIR).
- irq  out  1  registered interrupt request.

Behaviour:
- Reset is asynchronous and active-low, and clears every flop:
  - DATA_OUT = OUT_RESET; DIR, MASK, MODE, POL, STATUS, synchroniser, edge history and irq = 0.
  - Result: pio_o = OUT_RESET, pio_oe = 0, irq = 0, avs_readdata follows the decode.
  - Reset asserted mid-operation drops irq and pio_oe immediately, without waiting for a clock edge.
- Register map (any other address: reads 0, writes ignored):
  - 0x00 DATA: read = DIR ? DATA_OUT : in_f (per bit); write loads DATA_OUT.
  - 0x04 DIR: 1 = output. Read/write.
  - 0x08 IRQ_MASK: read/write.
  - 0x0C IRQ_MODE: 0 = level, 1 = edge. Read/write.
  - 0x10 IRQ_POL: in level mode 1 = active-high, 0 = active-low; in edge mode 1 = rising, 0 = falling. Read/write.
  - 0x14 IRQ_STATUS: read = sticky status; write 1 clears that bit, write 0 has no effect.
  - 0x18 OUT_SET: DATA_OUT |= wdata. Reads 0.
  - 0x1C OUT_CLR: DATA_OUT &= ~wdata. Reads 0.
- Register writes take effect at the clock edge where avs_write = 1. Outputs reflect the new value from that edge onward.
- Input path:
  - pio_i passes through SYNC_STAGES flops to give in_s.
  - in_f = in_s, or the debounced value when GPIO_DEBOUNCE_EN is defined.
  - prev_f is in_f registered one cycle.
- Interrupt detect, per bit i, only when DIR[i] = 0:
  - Level mode: ev[i] = (in_f[i] == POL[i]).
  - Edge mode, rising: ev[i] = in_f[i] & ~prev_f[i].
  - Edge mode, falling: ev[i] = ~in_f[i] & prev_f[i].
  - Output bits (DIR[i] = 1) never raise ev.
- STATUS[i] update:
  - Set to 1 on any clock where ev[i] = 1, independent of MASK.
  - Cleared by a W1C write.
  - A simultaneous set and W1C on the same bit: set wins, so no event is lost.
  - In level mode, clearing while the level is still active re-sets the bit on the same edge.
- irq <= |(STATUS & IRQ_MASK), registered.
  - Unmasking a bit whose status is already set raises irq on the next edge.
  - Masking that bit drops irq on the next edge.
- Latency, without debounce: a pin transition stable before capture edge 1 gives:
  - in_f updated after edge SYNC_STAGES;
  - STATUS set after edge SYNC_STAGES+1;
  - irq = 1 after edge SYNC_STAGES+2.
- Changing MODE or POL does not clear STATUS. Edge history prev_f keeps updating regardless of MASK and DIR.
- Changing DIR from 1 to 0 can produce an edge event if in_f differs from prev_f. This is intended.
- OUT_SET and OUT_CLR writes are atomic single-cycle read-modify-write operations; simultaneous CPU access is impossible on the single port.

Optional Feature:
- Macro: GPIO_DEBOUNCE_EN.
- Defined:
  - Each bit has a counter of width $clog2(DEBOUNCE_CYCLES+1) and a filtered flop in_f.
  - While in_s[i] == in_f[i], the counter resets to 0.
  - Otherwise the counter increments. When it reaches DEBOUNCE_CYCLES, in_f[i] takes in_s[i] and the counter resets.
  - A glitch shorter than DEBOUNCE_CYCLES cycles never reaches in_f.
  - All latencies above grow by DEBOUNCE_CYCLES.
  - Counters and in_f reset to 0.
- Not defined: in_f = in_s. No counter logic is synthesised.

Test Plan:
- Reset with OUT_RESET=32'hA5 -> pio_o=0xA5, pio_oe=0, irq=0. Read DIR returns 0. Read 0x14 returns 0.
- Write DATA=0xF0, then OUT_SET=0x0F, then OUT_CLR=0x81 -> pio_o=0xF0, then 0xFF, then 0x7E. Reads of 0x18 and 0x1C return 0.
- MODE[3]=1, POL[3]=1, MASK[3]=1; pio_i[3] 0->1 -> STATUS=0x08 after edge 3 and irq=1 after edge 4 (SYNC_STAGES=2). Write 0x14=0x08 -> STATUS=0 and irq=0 one edge later. A 1->0 transition raises no event.
- Level-low on bit 0 (MODE=0, POL=0), pin held at 0 -> W1C of 0x01 leaves STATUS[0]=1. After the pin goes to 1, W1C clears it.
- W1C of bit 5 in the same cycle as its rising-edge event -> STATUS[5] stays 1. Setting DIR[5]=1 suppresses all further events on bit 5.
- With GPIO_DEBOUNCE_EN and DEBOUNCE_CYCLES=4: a 3-cycle pulse -> no STATUS change; a 6-cycle pulse -> STATUS set 4 cycles later than in the non-debounced build.
